// File: rtl/mem_bank_arb_pkg.sv
// Shared types and constants for the banked-memory arbiters and controllers.
// Covers the requester-index type and the degenerate-configuration markers.
package mem_bank_arb_pkg;

    // Configuration markers: purely combinational response path, single requester.
    localparam int LatComb   = 0;
    localparam int SingleReq = 1;

    // Widest requester index carried between the bank arbiters and controllers.
    localparam int MaxIdxW = 8;
    typedef logic [MaxIdxW-1:0] req_idx_t;

    // Requester-index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bank_rsp_pipe.sv
// Fixed-latency response tracker: shifts {valid, requester index} alongside the
// bank read pipeline so each grant produces exactly one response Depth cycles later.
module mem_bank_rsp_pipe
    import mem_bank_arb_pkg::*;
#(
    parameter int Depth    = 2,
    parameter int IdxWidth = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    input  logic [IdxWidth-1:0] in_idx_i,
    output logic                out_valid_o,
    output logic [IdxWidth-1:0] out_idx_o,
    output logic                busy_o
);

    generate
        if (Depth == LatComb) begin : g_comb
            // Nothing is ever in flight; the response is the grant itself.
            assign out_valid_o = in_valid_i & rst_ni;
            assign out_idx_o   = in_idx_i;
            assign busy_o      = 1'b0;
        end else begin : g_pipe
            logic [Depth-1:0]               vld_q;
            logic [Depth-1:0][IdxWidth-1:0] idx_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    idx_q <= '0;
                end else begin
                    vld_q[0] <= in_valid_i;
                    idx_q[0] <= in_idx_i;
                    for (int s = 1; s < Depth; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        idx_q[s] <= idx_q[s-1];
                    end
                end
            end

            assign out_valid_o = vld_q[Depth-1];
            assign out_idx_o   = idx_q[Depth-1];
            assign busy_o      = |vld_q;
        end
    endgenerate

endmodule

// File: rtl/mem_bank_rr_arbiter.sv
// Round-robin arbiter sharing one always-ready memory bank among NumReq requesters,
// routing each fixed-latency response back to the requester that was granted.
module mem_bank_rr_arbiter
    import mem_bank_arb_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int AddrWidth  = 13,
    parameter int DataWidth  = 64,
    parameter int MemLatency = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_i,
    output logic [NumReq-1:0]                    gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   strb_i,
    input  logic [NumReq-1:0]                    we_i,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 mem_req_o,
    output logic [AddrWidth-1:0]                 mem_addr_o,
    output logic [DataWidth-1:0]                 mem_wdata_o,
    output logic [DataWidth/8-1:0]               mem_be_o,
    output logic                                 mem_we_o,
    input  logic [DataWidth-1:0]                 mem_rdata_i,
    output logic                                 busy_o
);

    localparam int IdxW = idx_width(NumReq);

    logic [IdxW-1:0] gnt_idx;
    logic            rsp_valid;
    logic [IdxW-1:0] rsp_idx;

    assign mem_req_o = |req_i;

    generate
        if (NumReq == SingleReq) begin : g_single
            assign gnt_o       = req_i;
            assign gnt_idx     = '0;
            assign mem_addr_o  = addr_i[0];
            assign mem_wdata_o = wdata_i[0];
            assign mem_be_o    = strb_i[0];
            assign mem_we_o    = we_i[0];
        end else begin : g_rr
            logic [IdxW-1:0]   ptr_q, ptr_d;
            logic [NumReq-1:0] gnt_c;
            logic [IdxW-1:0]   idx_c;
            logic              found;
            req_idx_t          cand;

            // First requester at or after the pointer, wrapping modulo NumReq.
            always_comb begin
                gnt_c = '0;
                idx_c = '0;
                found = 1'b0;
                cand  = '0;
                for (int i = 0; i < NumReq; i++) begin
                    cand = req_idx_t'((int'(ptr_q) + i) % NumReq);
                    if (!found && req_i[cand[IdxW-1:0]]) begin
                        found = 1'b1;
                        idx_c = cand[IdxW-1:0];
                    end
                end
                if (found) gnt_c[idx_c] = 1'b1;
            end

            assign ptr_d = !found                         ? ptr_q :
                           (idx_c == IdxW'(NumReq - 1))   ? '0    :
                                                            idx_c + 1'b1;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) ptr_q <= '0;
                else         ptr_q <= ptr_d;
            end

            assign gnt_o       = gnt_c;
            assign gnt_idx     = idx_c;
            assign mem_addr_o  = addr_i[idx_c];
            assign mem_wdata_o = wdata_i[idx_c];
            assign mem_be_o    = strb_i[idx_c];
            assign mem_we_o    = we_i[idx_c];
        end
    endgenerate

    // Writes are tracked too so every grant gets exactly one response.
    mem_bank_rsp_pipe #(
        .Depth    (MemLatency),
        .IdxWidth (IdxW)
    ) u_rsp_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (mem_req_o),
        .in_idx_i    (gnt_idx),
        .out_valid_o (rsp_valid),
        .out_idx_o   (rsp_idx),
        .busy_o      (busy_o)
    );

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            rvalid_o[k] = rsp_valid && (rsp_idx == IdxW'(k));
        end
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_bank_rr_arbiter.sv
// Scoreboard bench for mem_bank_rr_arbiter: a latency-2 instance against a bank
// model, plus a latency-0 instance sharing the same request stream.
module tb_mem_bank_rr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 13;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          req;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0][SW-1:0]  strb;
    logic [N-1:0]          we;

    logic [N-1:0]  gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_be;

    logic [N-1:0]  gnt0, rvalid0;
    logic [DW-1:0] rdata0, mem_wdata0;
    logic          mem_req0, mem_we0, busy0;
    logic [AW-1:0] mem_addr0;
    logic [SW-1:0] mem_be0;
    logic [DW-1:0] mem_rdata0 = '0;

    mem_bank_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MemLatency(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt),
        .addr_i(addr), .wdata_i(wdata), .strb_i(strb), .we_i(we),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_bank_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MemLatency(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt0),
        .addr_i(addr), .wdata_i(wdata), .strb_i(strb), .we_i(we),
        .rvalid_o(rvalid0), .rdata_o(rdata0),
        .mem_req_o(mem_req0), .mem_addr_o(mem_addr0), .mem_wdata_o(mem_wdata0),
        .mem_be_o(mem_be0), .mem_we_o(mem_we0), .mem_rdata_i(mem_rdata0), .busy_o(busy0)
    );

    // Bank model: 32 words, byte-enabled writes, two-cycle read latency.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (mem_req && mem_we)
            for (int b = 0; b < SW; b++)
                if (mem_be[b]) mem[mem_addr[4:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        rd_p0 <= mem[mem_addr[4:0]];
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    typedef struct {
        int          due;
        int          idx;
        bit          rd;
        logic [63:0] data;
    } rsp_t;

    rsp_t          q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            ptr_m   = 0;
    int            waitc   [N];
    int            gcnt    [N];
    int            rcnt    [N];
    logic [N-1:0]  last_g;
    logic [N-1:0]  last_rv;
    logic [DW-1:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance.
    task automatic step();
        logic [N-1:0] eg, erv;
        logic [63:0]  edat;
        bit           erd, ebusy;
        int           gi, k;
        rsp_t         e;
        @(negedge clk);
        eg = '0; gi = -1;
        for (int i = 0; i < N; i++) begin
            k = (ptr_m + i) % N;
            if (gi < 0 && req[k]) gi = k;
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("gnt", gnt, eg);
        chk("gnt_onehot", ($countones(gnt) <= 1), 1);
        chk("mem_req", mem_req, |req);
        if (gi >= 0) begin
            chk("mem_addr", mem_addr, addr[gi]);
            chk("mem_we", mem_we, we[gi]);
            if (we[gi]) chk("mem_wdata", mem_wdata, wdata[gi]);
        end
        erv = '0; erd = 0; edat = '0; ebusy = 0;
        if (!rst_n) q.delete();
        foreach (q[j]) if (q[j].due >= cyc) ebusy = 1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            erv[e.idx] = 1'b1; erd = e.rd; edat = e.data;
        end
        chk("rvalid", rvalid, erv);
        if (erd) chk("rdata", rdata, edat);
        chk("busy", busy, ebusy);
        chk("gnt_lat0", gnt0, eg);
        chk("rvalid_lat0", rvalid0, rst_n ? eg : '0);
        chk("busy_lat0", busy0, 0);
        for (int j = 0; j < N; j++) begin
            if (gnt[j])    gcnt[j]++;
            if (rvalid[j]) rcnt[j]++;
            if (!rst_n) waitc[j] = 0;
            else if (gnt[j]) begin
                chk("wait_bound", (waitc[j] <= N - 1), 1);
                waitc[j] = 0;
            end else if (req[j]) waitc[j]++;
            else waitc[j] = 0;
        end
        last_g = gnt; last_rv = rvalid; last_rd = rdata;
        if (!rst_n) ptr_m = 0;
        else if (gi >= 0) begin
            q.push_back('{cyc + LAT, gi, !we[gi], mem[addr[gi][4:0]]});
            ptr_m = (gi + 1) % N;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int nrand;
        req = '0; addr = '0; wdata = '0; strb = '0; we = '0;
        for (int j = 0; j < N; j++) begin waitc[j] = 0; gcnt[j] = 0; rcnt[j] = 0; end

        // Reset: grants still combinational, no responses, busy low.
        step();
        req = 4'b1010;
        step();
        req = '0;
        rst_n = 1'b1;

        // Fairness from reset: all requesting for 8 cycles.
        req = '1;
        for (int i = 0; i < 8; i++) step();
        idle(3);

        // Pointer skipping: move pointer to 1, then 1001 -> 3 then 0.
        req = 4'b0001; step();
        req = 4'b1001; step();
        step();
        idle(3);

        // Read routing: requester 2 writes addr 5, requester 0 reads it back.
        req = 4'b0100; we[2] = 1'b1; addr[2] = 13'd5;
        wdata[2] = 64'hDEADBEEF_CAFEF00D; strb[2] = 8'hFF;
        step();
        req = 4'b0001; we[0] = 1'b0; addr[0] = 13'd5;
        step();
        req = '0;
        step();
        step();
        chk("route_rvalid", last_rv, 4'b0001);
        chk("route_rdata", last_rd, 64'hDEADBEEF_CAFEF00D);
        idle(2);

        // Latency-0 instance sees the same single request.
        req = 4'b0100; we[2] = 1'b0;
        step();
        idle(3);

        // Mid-flight reset: grant to 1 (pointer -> 2), reset drops it.
        req = 4'b0010; we[1] = 1'b0;
        step();
        req = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        req = '1;
        step();
        chk("post_reset_gnt", last_g, 4'b0001);
        idle(3);

        // Random traffic: requests held until granted.
        for (int j = 0; j < N; j++) begin gcnt[j] = 0; rcnt[j] = 0; end
        req = '0;
        nrand = 0;
        while (nrand < 10000 && cyc < 80000) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && last_g[j]) begin
                    req[j] = 1'b0;
                    nrand++;
                end
                if (!req[j] && $urandom_range(0, 9) < 6) begin
                    req[j]   = 1'b1;
                    we[j]    = 1'($urandom_range(0, 1));
                    addr[j]  = AW'($urandom_range(0, 31));
                    wdata[j] = {$urandom, $urandom};
                    strb[j]  = SW'($urandom);
                end
            end
            step();
        end
        chk("random_done", (nrand >= 10000), 1);
        idle(LAT + 2);
        for (int j = 0; j < N; j++) chk("rsp_eq_gnt", rcnt[j], gcnt[j]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_rr_arbiter.md
MEM_BANK_RR_ARBITER -- requirements
Module: mem_bank_rr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters sharing one bank (>=1).
REQ-002 SHALL have parameter AddrWidth, default 13, bank word-address width.
REQ-003 SHALL have parameter DataWidth, default 64, bank data width (multiple of 8).
REQ-004 SHALL have parameter MemLatency, default 2, fixed bank read latency in cycles (>=0).
REQ-005 SHALL have port clk_i  in  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port req_i  in  NumReq  per-requester request.
REQ-008 SHALL have port gnt_o  out  NumReq  per-requester grant, one-hot or zero.
REQ-009 SHALL have ports addr_i / wdata_i / strb_i / we_i  in  NumReq x AddrWidth / DataWidth / DataWidth/8 / 1  per-requester payload.
REQ-010 SHALL have port rvalid_o  out  NumReq  per-requester response valid.
REQ-011 SHALL have port rdata_o  out  DataWidth  response data, shared by all requesters and qualified by rvalid_o.
REQ-012 SHALL have ports mem_req_o / mem_addr_o / mem_wdata_o / mem_be_o / mem_we_o  out  1 / AddrWidth / DataWidth / DataWidth/8 / 1  bank request.
REQ-013 SHALL have port mem_rdata_i  in  DataWidth  bank read data, valid MemLatency cycles after the request.
REQ-014 SHALL have port busy_o  out  1  high while any response is in flight.

Function
REQ-015 SHALL treat the bank as always ready: at most one request per cycle, accepted in the cycle it is issued.
REQ-016 SHALL grant combinationally in the same cycle: gnt_o[k]=1 for the first requesting index k at or after the priority pointer, modulo NumReq.
REQ-017 SHALL drive mem_req_o=|req_i and drive the mem_* payload from the granted requester; when mem_req_o=0, the payload is don't-care.
REQ-018 SHALL, after a grant to k, set the pointer to (k+1) mod NumReq on the next edge; with no request, the pointer holds.
REQ-019 SHALL require requesters to hold req_i and payload stable until granted; a request dropped before grant is ignored without error.
REQ-020 SHALL produce exactly one response per grant, for writes and reads alike: rvalid_o[k]=1 exactly MemLatency cycles after gnt_o[k].
REQ-021 SHALL route rdata_o=mem_rdata_i in the response cycle; for writes, rdata_o is don't-care.
REQ-022 SHALL track responses with a MemLatency-deep shift pipeline of {valid, requester index ($clog2(NumReq) bits, min 1)}.
REQ-023 SHALL keep the pipeline full-throughput: back-to-back grants every cycle and no stalls.
REQ-024 SHALL, when MemLatency=0, drive rvalid_o=gnt_o combinationally, with no pipeline registers.
REQ-025 SHALL, when NumReq=1, pass the requester through with gnt_o=req_i and no pointer state.
REQ-026 SHALL drive busy_o as the OR of all pipeline valid bits; busy_o=0 when MemLatency=0.
REQ-027 SHALL, on simultaneous grant and response in one cycle (same or different requester), serve both independently.

Reset
REQ-028 SHALL, while rst_ni=0, hold the pointer at 0, clear all pipeline valids, and hold rvalid_o=0 and busy_o=0; gnt_o and mem_req_o remain combinational from req_i.
REQ-029 SHALL, on reset assertion mid-operation, drop in-flight responses with no late rvalid after release; the pointer restarts at 0.

Structure
REQ-030 SHALL place the requester-index typedef and the MemLatency=0/NumReq=1 handling constants in package mem_bank_arb_pkg, shared with the banked-memory controllers.
REQ-031 SHALL implement the response tracker as sub-module mem_bank_rsp_pipe (parameters Depth, IdxWidth; ports clk_i, rst_ni, in_valid_i, in_idx_i, out_valid_o, out_idx_o, busy_o).

Verification
REQ-032 SHALL verify fairness: NumReq=4, MemLatency=2, all req_i=1 for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; each rvalid_o[k] is seen 2 cycles after its grant.
REQ-033 SHALL verify pointer skipping: pointer=1, req_i=4'b1001 -> gnt_o=4'b1000, next pointer=0; next cycle same req -> gnt_o=4'b0001.
REQ-034 SHALL verify read routing: requester 2 writes 0xDEADBEEF_CAFEF00D to addr 5 with strb=0xFF, then requester 0 reads addr 5 -> rvalid_o=4'b0001 two cycles after grant with rdata_o=0xDEADBEEF_CAFEF00D.
REQ-035 SHALL verify mid-flight reset: grant at cycle t, rst_ni low at t+1 -> no rvalid_o at t+2 or later, busy_o=0, and the first grant after release follows pointer 0.
REQ-036 SHALL verify MemLatency=0: req_i=4'b0100 -> gnt_o=rvalid_o=4'b0100 in the same cycle and busy_o stays 0.
REQ-037 SHALL verify under random traffic, 10000 requests: responses per requester equal grants per requester; no cycle has more than one gnt_o bit set; no requester waits more than NumReq-1 cycles while requesting.
